// File: rtl/fir_rd_dma.sv
// AXI4 read-master DMA feeding the FIR core input.
// A transfer of `len` words is split into INCR bursts that never cross a
// 4 KB boundary. Up to OUTSTANDING_COUNT bursts may be in flight, and FIFO
// space is reserved before each AR, so the R channel is never stalled.
`timescale 1ns/1ps

module fir_rd_dma #(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int AXI_MAX_BURST_LEN = 16,
    parameter int OUTSTANDING_COUNT = 2,
    parameter int TOP_LEN_WIDTH     = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [TOP_LEN_WIDTH-1:0]  len,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready
);

    localparam int DW    = AXI_DATA_WIDTH;
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int LW    = TOP_LEN_WIDTH;
    localparam int SW    = $clog2(AXI_DATA_WIDTH / 8);
    localparam int DEPTH = OUTSTANDING_COUNT * AXI_MAX_BURST_LEN;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = $clog2(OUTSTANDING_COUNT + 1);

    localparam logic [AW-1:0] ALIGN_MASK = ~AW'((32'd1 << SW) - 32'd1);
    localparam logic [LW-1:0] ONE_LW     = LW'(32'd1);
    localparam logic [LW-1:0] MAXB_LW    = LW'(AXI_MAX_BURST_LEN);
    localparam logic [LW-1:0] PAGE_WORDS = LW'(32'd4096 >> SW);
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    logic            busy_r;
    logic            done_r;
    logic            err_r;

    logic [AW-1:0]   addr_r;
    logic [LW-1:0]   remain_r;
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   pop_cnt_r;

    logic            arvalid_r;
    logic [AW-1:0]   araddr_r;
    logic [7:0]      arlen_r;

    logic [OW-1:0]   outst_r;
    logic [CW-1:0]   rsv_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [DW-1:0]   mem_r [DEPTH];

    logic            out_valid_r;
    logic            out_last_r;
    logic [DW-1:0]   out_data_r;

    logic            start_acc_s;
    logic            ar_hs_s;
    logic            r_hs_s;
    logic            r_end_s;
    logic            out_hs_s;
    logic            fin_s;
    logic            load_s;
    logic            issue_s;
    logic [LW-1:0]   rem_cap_s;
    logic [LW-1:0]   bnd_words_s;
    logic [LW-1:0]   beats_s;
    logic [CW-1:0]   free_s;
    logic [CW-1:0]   rsv_add_s;
    logic [CW-1:0]   rsv_sub_s;

    // Handshake and event decode shared by every register block
    always_comb begin
        start_acc_s = start && (state_r == ST_IDLE) && !busy_r;
        ar_hs_s     = arvalid_r && m_axi_arready;
        r_hs_s      = m_axi_rvalid && busy_r;
        r_end_s     = r_hs_s && m_axi_rlast;
        out_hs_s    = out_valid_r && out_ready;
        fin_s       = out_hs_s && out_last_r;
        load_s      = (count_r != {CW{1'b0}}) && (!out_valid_r || out_ready);
    end

    // Burst sizing: min(remaining words, max burst, words left in the 4 KB page)
    always_comb begin
        rem_cap_s   = remain_r;
        bnd_words_s = PAGE_WORDS - LW'(addr_r[11:SW]);
        beats_s     = remain_r;
        if (remain_r > MAXB_LW) begin
            rem_cap_s = MAXB_LW;
        end else begin
            rem_cap_s = remain_r;
        end
        if (bnd_words_s < rem_cap_s) begin
            beats_s = bnd_words_s;
        end else begin
            beats_s = rem_cap_s;
        end
    end

    // AR issue gate: one AR at a time, bounded bursts in flight, space reserved
    always_comb begin
        free_s  = CW'(DEPTH) - count_r - rsv_r;
        issue_s = (state_r == ST_ISSUE) && !arvalid_r &&
                  (remain_r != {LW{1'b0}}) &&
                  (outst_r < OW'(OUTSTANDING_COUNT)) &&
                  (LW'(free_s) >= beats_s);
    end

    // Reservation deltas: AR handshake reserves a burst, each R beat consumes one
    always_comb begin
        rsv_add_s = {CW{1'b0}};
        rsv_sub_s = {CW{1'b0}};
        if (ar_hs_s) begin
            rsv_add_s = CW'(arlen_r) + CW'(1'b1);
        end else begin
            rsv_add_s = {CW{1'b0}};
        end
        if (r_hs_s) begin
            rsv_sub_s = CW'(1'b1);
        end else begin
            rsv_sub_s = {CW{1'b0}};
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s && (len != {LW{1'b0}})) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs_s && (remain_r == {LW{1'b0}})) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (fin_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // busy/done/err status; a zero-length start gives a single busy+done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (start_acc_s) begin
                busy_r <= 1'b1;
                done_r <= (len == {LW{1'b0}});
            end else if (fin_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else if (busy_r && (state_r == ST_IDLE)) begin
                busy_r <= 1'b0;
                done_r <= 1'b0;
            end else begin
                done_r <= 1'b0;
            end
            if (start_acc_s) begin
                err_r <= 1'b0;
            end else if (r_hs_s && (m_axi_rresp != 2'b00)) begin
                err_r <= 1'b1;
            end
        end
    end

    // Transfer bookkeeping: next burst address and words not yet requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= {AW{1'b0}};
            remain_r <= {LW{1'b0}};
            len_r    <= {LW{1'b0}};
        end else if (start_acc_s) begin
            addr_r   <= base_addr & ALIGN_MASK;
            remain_r <= len;
            len_r    <= len;
        end else if (issue_s) begin
            addr_r   <= addr_r + (AW'(beats_s) << SW);
            remain_r <= remain_r - beats_s;
        end
    end

    // AR channel registers; address and length stay frozen until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_r <= 1'b0;
            araddr_r  <= {AW{1'b0}};
            arlen_r   <= 8'd0;
        end else if (issue_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= addr_r;
            arlen_r   <= 8'(beats_s - ONE_LW);
        end else if (ar_hs_s) begin
            arvalid_r <= 1'b0;
        end
    end

    // Outstanding-burst and reserved-entry counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_r <= {OW{1'b0}};
            rsv_r   <= {CW{1'b0}};
        end else begin
            case ({ar_hs_s, r_end_s})
                2'b10:   outst_r <= outst_r + OW'(1'b1);
                2'b01:   outst_r <= outst_r - OW'(1'b1);
                default: outst_r <= outst_r;
            endcase
            rsv_r <= rsv_r + rsv_add_s - rsv_sub_s;
        end
    end

    // FIFO pointers and occupancy; push is an R beat, pop loads the output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (r_hs_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PW{1'b0}} : wr_ptr_r + PW'(1'b1);
            end
            if (load_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PW{1'b0}} : rd_ptr_r + PW'(1'b1);
            end
            case ({r_hs_s, load_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage write (data array needs no reset)
    always_ff @(posedge clk) begin
        if (r_hs_s) begin
            mem_r[wr_ptr_r] <= m_axi_rdata;
        end
    end

    // Registered output stage; holds data while the FIR core stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            pop_cnt_r   <= {LW{1'b0}};
        end else begin
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mem_r[rd_ptr_r];
                out_last_r  <= (pop_cnt_r == (len_r - ONE_LW));
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            if (start_acc_s) begin
                pop_cnt_r <= {LW{1'b0}};
            end else if (load_s) begin
                pop_cnt_r <= pop_cnt_r + ONE_LW;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arsize  = 3'(SW);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = busy_r;
    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign out_last      = out_last_r;

endmodule

// File: tb/tb_fir_rd_dma.sv
// Bench for fir_rd_dma: randomised AXI read slave, scoreboard of expected
// output words, table of transfers plus hand-written corner sequences.
`timescale 1ns/1ps

module tb_fir_rd_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [19:0] len;
    logic        busy, done, err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] out_data;
    logic        out_valid, out_last, out_ready;

    always #5 clk = ~clk;

    fir_rd_dma dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .err(err),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] base;
        int          len;
        int          hold;      // cycles with out_ready=0 before release
        int          orm;       // 0: out_ready always 1, 1: random
        int          err_beat;  // 1-based beat given SLVERR, 0 = none
        int          nar;
        logic [31:0] a0;
        int          l0;
        logic [31:0] a1;
        int          l1;
        logic        err;
    } vec_t;

    typedef struct { logic [31:0] data; logic last; } exp_t;
    typedef struct { logic [31:0] addr; int beats; } burst_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

    exp_t   exp_q[$];
    burst_t bq[$];
    ar_t    ar_log[$];
    vec_t   vt[6];

    int   nvec = 0;
    int   nfail = 0;
    int   orm = 0;
    int   err_beat = 0;
    int   gbeat = 0;
    int   beat_idx = 0;
    int   done_cnt = 0;
    int   outst = 0;
    int   max_outst = 0;
    logic busy_at_done = 1'b0;
    logic arv_seen = 1'b0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0F1E_2D3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AXI read slave, AR protocol monitor and output scoreboard
    initial begin : slave
        logic        ar_f, r_f, o_f, rl, hold_p;
        logic [31:0] cap_a, hold_a, endb;
        logic [7:0]  cap_l, hold_l;
        exp_t        e;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        rlast = 1'b0; out_ready = 1'b0; hold_p = 1'b0;
        forever begin
            @(negedge clk);
            ar_f  = rst_n && arvalid && arready;
            r_f   = rst_n && rvalid && rready;
            rl    = rlast;
            o_f   = rst_n && out_valid && out_ready;
            cap_a = araddr;
            cap_l = arlen;
            if (rst_n && arvalid) arv_seen = 1'b1;
            if (hold_p && rst_n) begin
                check("ar_hold_valid", 32'(arvalid), 32'd1);
                check("ar_hold_addr", araddr, hold_a);
                check("ar_hold_len", 32'(arlen), 32'(hold_l));
            end
            hold_p = rst_n && arvalid && !arready;
            hold_a = araddr;
            hold_l = arlen;
            if (ar_f) begin
                ar_log.push_back('{araddr, arlen});
                endb = {20'd0, araddr[11:0]} + (32'(arlen) + 32'd1) * 32'd4;
                check("ar_no_4k_cross", 32'(endb <= 32'd4096), 32'd1);
                outst++;
            end
            if (r_f && rl) outst--;
            if (outst > max_outst) max_outst = outst;
            if (rst_n && done) begin
                done_cnt++;
                busy_at_done = busy;
            end
            if (o_f) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bq.delete();
                beat_idx = 0;
                rvalid = 1'b0;
                rlast = 1'b0;
                arready = 1'b0;
            end else begin
                if (ar_f) bq.push_back('{cap_a, int'(cap_l) + 1});
                if (r_f) begin
                    rvalid = 1'b0;
                    beat_idx++;
                    if (bq.size() > 0 && beat_idx >= bq[0].beats) begin
                        void'(bq.pop_front());
                        beat_idx = 0;
                    end
                end
                if (!rvalid && bq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    gbeat++;
                    rdata  = data_of(bq[0].addr + 32'(beat_idx * 4));
                    rlast  = (beat_idx == bq[0].beats - 1);
                    rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
                    rvalid = 1'b1;
                end
                arready = ($urandom_range(0, 2) != 0);
            end
            out_ready = (orm == 0) ? 1'b1 : (orm == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic prep(input vec_t v);
        exp_q.delete();
        ar_log.delete();
        done_cnt  = 0;
        gbeat     = 0;
        err_beat  = v.err_beat;
        max_outst = 0;
        for (int i = 0; i < v.len; i++)
            exp_q.push_back('{data_of((v.base & 32'hFFFF_FFFC) + 32'(i * 4)), (i == v.len - 1)});
    endtask

    task automatic pulse_start(input logic [31:0] b, input int n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = 20'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        prep(v);
        orm = (v.hold > 0) ? 2 : v.orm;
        pulse_start(v.base, v.len);
        check("err_cleared_by_start", 32'(err), 32'd0);
        if (v.hold > 0) begin
            repeat (v.hold) @(posedge clk);
            @(negedge clk);
            check("hold_ar_count", 32'(ar_log.size()), 32'd2);
            check("hold_arvalid_low", 32'(arvalid), 32'd0);
            for (int i = 0; i < ar_log.size(); i++)
                check("hold_arlen", 32'(ar_log[i].len), 32'd15);
            orm = v.orm;
        end
        for (k = 0; k < 20000 && done_cnt == 0; k++) @(negedge clk);
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (5) @(negedge clk);
        check("done_once", 32'(done_cnt), 32'd1);
        check("busy_low_at_done", 32'(busy_at_done), 32'd0);
        check("busy_low_after", 32'(busy), 32'd0);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("ar_count", 32'(ar_log.size()), 32'(v.nar));
        if (ar_log.size() >= 1) begin
            check("ar0_addr", ar_log[0].addr, v.a0);
            check("ar0_len", 32'(ar_log[0].len), 32'(v.l0));
        end
        if (v.nar >= 2 && ar_log.size() >= 2) begin
            check("ar1_addr", ar_log[1].addr, v.a1);
            check("ar1_len", 32'(ar_log[1].len), 32'(v.l1));
        end
        check("err_final", 32'(err), 32'(v.err));
        check("max_outstanding", 32'(max_outst <= 2), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arlen", 32'(arlen), 32'd0);
        check("rst_arsize", 32'(arsize), 32'd2);
        check("rst_arburst", 32'(arburst), 32'd1);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
    endtask

    initial begin : main
        vt[0] = '{32'h0000_00B8,  23,   0, 0, 0, 2, 32'h0B8,  15, 32'h0F8,  6, 1'b0};
        vt[1] = '{32'h0000_0FF8,   8,   0, 1, 0, 2, 32'hFF8,   1, 32'h1000, 5, 1'b0};
        vt[2] = '{32'h0000_2000, 100, 200, 1, 0, 7, 32'h2000, 15, 32'h2040, 15, 1'b0};
        vt[3] = '{32'h0000_3000,  16,   0, 1, 3, 1, 32'h3000, 15, 32'h0,    0, 1'b1};
        vt[4] = '{32'h0000_01F3,  37,   0, 1, 0, 3, 32'h1F0,  15, 32'h230,  15, 1'b0};
        vt[5] = '{32'h0000_4000,   5,   0, 0, 0, 1, 32'h4000,  4, 32'h0,    0, 1'b0};

        rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; len = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // zero-length transfer with a second start during its busy cycle
        exp_q.delete(); ar_log.delete(); done_cnt = 0; arv_seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h500; len = 20'd0;
        @(posedge clk); #1;
        len = 20'd5;
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_busy_drop", 32'(busy), 32'd0);
        check("len0_done_drop", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        check("len0_no_arvalid", 32'(arv_seen), 32'd0);
        check("len0_idle", 32'(busy), 32'd0);
        check("len0_done_once", 32'(done_cnt), 32'd1);

        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("err_sticky_before_start", 32'(err), 32'd1);
            run_vec(vt[i]);
        end

        // reset in the middle of a stalled long transfer
        prep(vt[2]);
        orm = 2;
        pulse_start(32'h2000, 100);
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        outst = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_vec(vt[5]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
